pipe_ctrl_unit: RTL
===================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter ALUOP_W, default 3, meaning ALU-op code width; legal range is 3 or more.
REQ-002 Parameter SUPPORT_JUMP, default 1, meaning JAL/JALR decoded when 1 and treated as illegal when 0.
REQ-003 Parameter CNT_W, default 8, meaning illegal-instruction counter width.
REQ-004 One clock; reset is synchronous and active-low. Ports clk, rst_n.
REQ-005 Ports: name direction width meaning.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds an instruction
- id_opcode  in  7  instruction[6:0]
- id_funct3  in  3  instruction[14:12]
- id_rs1, id_rs2  in  5  source registers
- id_rd  in  5  destination register
- stall_ext  in  1  external stall request
- flush  in  1  squash the ID instruction (taken branch or jump)
- hazard_stall  out  1  load-use stall for PC and IF/ID hold
- ex_alu_op  out  ALUOP_W  ALU operation
- ex_alu_src  out  1  ALU operand B is immediate
- ex_branch, ex_jump, ex_jalr  out  1  each: control-flow class
- ex_rd  out  5  EX destination register
- mem_read, mem_write  out  1  each: data-memory strobes
- mem_funct3  out  3  access size
- wb_reg_write  out  1  register-file write
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 PC+4
- wb_rd  out  5  WB destination register
- illegal  out  1  one-cycle pulse on an illegal opcode
- illegal_cnt  out  CNT_W  saturating illegal-opcode count

Function
REQ-006 A combinational decode SHALL map id_opcode to the control bundle.
- LOAD 0000011: aluop ADDR=1, alu_src=1, mem_read=1, reg_write=1, wb_sel=1.
- STORE 0100011: aluop=1, alu_src=1, mem_write=1.
- R-type 0110011: aluop RTYPE=2, reg_write=1, wb_sel=0.
- BRANCH 1100011: aluop CMP=3, branch=1.
- OP-IMM 0010011: aluop IMM=0, alu_src=1, reg_write=1.
- LUI 0110111: aluop PASSB=4, alu_src=1, reg_write=1.
- JAL 1101111: jump=1, reg_write=1, wb_sel=2.
- JALR 1100111: jump=1, jalr=1, alu_src=1, aluop=1, reg_write=1, wb_sel=2.
REQ-007 Every don't-care field SHALL drive 0; no output SHALL ever be X.
REQ-008 Any other opcode with id_valid=1 SHALL be illegal: it decodes to a bubble (all controls 0) and sets illegal=1 on the next cycle.
REQ-009 illegal_cnt SHALL increment on each illegal decode and saturate at 2^CNT_W-1.
REQ-010 The bundle SHALL pass through registered ID/EX, EX/MEM and MEM/WB stages. An instruction presented at ID in cycle n appears on ex_* at n+1, mem_* at n+2 and wb_* at n+3.
REQ-011 hazard_stall SHALL be combinational and equal to id_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)). uses_rs2 is 1 for R-type, STORE and BRANCH.
REQ-012 When stall_ext, hazard_stall or flush is asserted, the ID/EX register SHALL load a bubble. EX/MEM and MEM/WB SHALL always advance.
REQ-013 Simultaneous flush and stall SHALL produce a single bubble; an illegal opcode under flush or stall SHALL NOT be counted.
REQ-014 id_valid=0 SHALL be treated as a bubble and SHALL NOT be counted as illegal.

Reset
REQ-015 With rst_n=0 at a clock edge, all pipeline registers, illegal and illegal_cnt SHALL clear to 0. This holds mid-operation and discards any in-flight bundle.
REQ-016 hazard_stall SHALL read 0 while in reset because the EX stage holds a bubble.

Structure
REQ-017 A shared package ctrl_pkg SHALL hold the following:
- opcode constants
- ALU-op codes IMM, ADDR, RTYPE, CMP, PASSB
- wb_sel codes
- the ctrl_bundle_t struct
REQ-018 Decode SHALL be a sub-module ctrl_decode (combinational). Staging, hazard logic and the counter SHALL reside in pipe_ctrl_unit.

Verification
REQ-019 LOAD at cycle 0 -> ex_alu_op=1 at cycle 1, mem_read=1 at cycle 2, wb_reg_write=1 with wb_sel=1 at cycle 3.
REQ-020 LOAD rd=5, then ADD rs2=5 -> hazard_stall=1 for one cycle with a bubble in EX; the ADD reaches EX one cycle later.
REQ-021 BRANCH in EX with flush=1 while JAL is in ID -> ex_jump stays 0 on the next cycle, and the branch continues to MEM and WB.
REQ-022 Opcode 1111111 issued 300 times with CNT_W=8 -> illegal pulses each time, illegal_cnt=255, and no writes occur.
REQ-023 SUPPORT_JUMP=0 with JAL -> illegal=1 and wb_reg_write stays 0.
REQ-024 rst_n=0 asserted with a STORE in MEM -> mem_write=0 after that edge and all outputs are 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================
// ctrl_pkg : opcodes, ALU-op / write-back codes, control bundle
// Rev 1.0
// ============================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_IMM   = 3'd0;
  localparam logic [2:0] ALU_ADDR  = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_CMP   = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================
// ctrl_decode : combinational opcode -> control bundle decode
// Rev 1.0
// ============================================================
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_JUMP = 1
) (
  input  logic         valid,
  input  logic [6:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         uses_rs2
);

  always_comb begin
    ctrl     = BUBBLE;
    illegal  = 1'b0;
    uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    if (valid) begin
      case (opcode)
        OP_LOAD: begin
          ctrl.alu_op = ALU_ADDR; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
          ctrl.reg_write = 1'b1;  ctrl.wb_sel = WB_MEM;
        end
        OP_STORE: begin
          ctrl.alu_op = ALU_ADDR; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        end
        OP_RTYPE: begin
          ctrl.alu_op = ALU_RTYPE; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_ALU;
        end
        OP_BRANCH: begin
          ctrl.alu_op = ALU_CMP; ctrl.branch = 1'b1;
        end
        OP_IMM: begin
          ctrl.alu_op = ALU_IMM; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_LUI: begin
          ctrl.alu_op = ALU_PASSB; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_JAL: begin
          if (SUPPORT_JUMP != 0) begin
            ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_PC4;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (SUPPORT_JUMP != 0) begin
            ctrl.jump = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src = 1'b1;
            ctrl.alu_op = ALU_ADDR; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_PC4;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ============================================================
// pipe_ctrl_unit : ID/EX/MEM/WB control staging, load-use hazard, illegal counter
// Rev 1.0
// ============================================================
`default_nettype none

module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W      = 3,
  parameter int SUPPORT_JUMP = 1,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               stall_ext,
  input  logic               flush,
  output logic               hazard_stall,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_jalr,
  output logic [4:0]         ex_rd,
  output logic               mem_read,
  output logic               mem_write,
  output logic [2:0]         mem_funct3,
  output logic               wb_reg_write,
  output logic [1:0]         wb_sel,
  output logic [4:0]         wb_rd,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  typedef struct packed {
    ctrl_bundle_t ctrl;
    logic [4:0]   rd;
    logic [2:0]   funct3;
  } ex_stage_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } wb_stage_t;

  ctrl_bundle_t w_dec_ctrl;
  logic         w_dec_illegal;
  logic         w_dec_uses_rs2;
  logic         w_squash;
  ex_stage_t    w_id_stage;
  ex_stage_t    r_ex;
  mem_stage_t   r_mem;
  wb_stage_t    r_wb;

  ctrl_decode #(
    .SUPPORT_JUMP (SUPPORT_JUMP)
  ) u_decode (
    .valid    (id_valid),
    .opcode   (id_opcode),
    .ctrl     (w_dec_ctrl),
    .illegal  (w_dec_illegal),
    .uses_rs2 (w_dec_uses_rs2)
  );

  assign hazard_stall = id_valid & r_ex.ctrl.mem_read & (r_ex.rd != 5'd0) &
                        ((r_ex.rd == id_rs1) | (w_dec_uses_rs2 & (r_ex.rd == id_rs2)));
  assign w_squash = stall_ext | hazard_stall | flush;

  // rd and funct3 are zeroed whenever the instruction does not use them
  always_comb begin
    w_id_stage = '0;
    if (!w_squash) begin
      w_id_stage.ctrl   = w_dec_ctrl;
      w_id_stage.rd     = w_dec_ctrl.reg_write ? id_rd : 5'd0;
      w_id_stage.funct3 = (w_dec_ctrl.mem_read | w_dec_ctrl.mem_write) ? id_funct3 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      r_ex  <= w_id_stage;
      r_mem <= '{mem_read:  r_ex.ctrl.mem_read,  mem_write: r_ex.ctrl.mem_write,
                 funct3:    r_ex.funct3,         reg_write: r_ex.ctrl.reg_write,
                 wb_sel:    r_ex.ctrl.wb_sel,    rd:        r_ex.rd};
      r_wb  <= '{reg_write: r_mem.reg_write, wb_sel: r_mem.wb_sel, rd: r_mem.rd};
      illegal <= w_dec_illegal & ~w_squash;
      if (w_dec_illegal && !w_squash && !(&illegal_cnt))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign ex_alu_op    = ALUOP_W'(r_ex.ctrl.alu_op);
  assign ex_alu_src   = r_ex.ctrl.alu_src;
  assign ex_branch    = r_ex.ctrl.branch;
  assign ex_jump      = r_ex.ctrl.jump;
  assign ex_jalr      = r_ex.ctrl.jalr;
  assign ex_rd        = r_ex.rd;
  assign mem_read     = r_mem.mem_read;
  assign mem_write    = r_mem.mem_write;
  assign mem_funct3   = r_mem.funct3;
  assign wb_reg_write = r_wb.reg_write;
  assign wb_sel       = r_wb.wb_sel;
  assign wb_rd        = r_wb.rd;

endmodule

`default_nettype wire
